// File: rtl/redux_pkg.sv
// rtl/redux_pkg.sv - shared widths, funct codes, FSM states and instruction layout for controle_ula
package redux_pkg;

    localparam int DATA_W  = 8;
    localparam int REG_N   = 4;
    localparam int IDX_W   = 2;
    localparam int FUNCT_W = 4;
    localparam int OPC_W   = 3;

    localparam logic [FUNCT_W-1:0] OP_NOT = 4'd0;
    localparam logic [FUNCT_W-1:0] OP_AND = 4'd1;
    localparam logic [FUNCT_W-1:0] OP_OR  = 4'd2;
    localparam logic [FUNCT_W-1:0] OP_XOR = 4'd3;
    localparam logic [FUNCT_W-1:0] OP_ADD = 4'd4;
    localparam logic [FUNCT_W-1:0] OP_SUB = 4'd5;
    localparam logic [FUNCT_W-1:0] OP_SHL = 4'd6;
    localparam logic [FUNCT_W-1:0] OP_SRR = 4'd7;
    localparam logic [FUNCT_W-1:0] F_LI   = 4'd8;
    localparam logic [FUNCT_W-1:0] F_MOV  = 4'd9;
    localparam logic [FUNCT_W-1:0] F_OUT  = 4'd10;

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        EXEC   = 2'd1,
        IMED   = 2'd2
    } estado_t;

    typedef struct packed {
        logic [FUNCT_W-1:0] funct;
        logic [IDX_W-1:0]   x;
        logic [IDX_W-1:0]   y;
    } instr_t;

    // Funct codes 0..7 map straight onto the ULA opcode
    function automatic logic is_alu(input logic [FUNCT_W-1:0] funct);
        return ~funct[FUNCT_W-1];
    endfunction

endpackage

// File: rtl/banco_regs.sv
// rtl/banco_regs.sv - 4x8 register file, two combinational read ports, one synchronous write port
module banco_regs
    import redux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  ra_addr_i,
    input  logic [IDX_W-1:0]  rb_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] regs_q [REG_N];

    assign ra_data_o = regs_q[ra_addr_i];
    assign rb_data_o = regs_q[rb_addr_i];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

endmodule

// File: rtl/controle_ula.sv
// rtl/controle_ula.sv - multicycle sequencer feeding the external 8-bit ULA from a private register file
module controle_ula
    import redux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] ula_ra,
    output logic [DATA_W-1:0] ula_rb,
    output logic [OPC_W-1:0]  ula_opcode,
    input  logic [DATA_W-1:0] ula_result,
    output logic [DATA_W-1:0] saida,
    output logic              saida_valid,
    output logic              zero
);

    instr_t            ins;
    estado_t           state_q;
    logic [IDX_W-1:0]  ir_x_q;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              hs;
    logic              we_d;
    logic [IDX_W-1:0]  wa_d;
    logic [DATA_W-1:0] wd_d;

    logic [DATA_W-1:0] ula_ra_q;
    logic [DATA_W-1:0] ula_rb_q;
    logic [OPC_W-1:0]  ula_opcode_q;
    logic [DATA_W-1:0] saida_q;
    logic              saida_valid_q;
    logic              zero_q;

    assign ins         = instr_t'(instr);
    assign instr_ready = (state_q != EXEC);
    assign hs          = instr_valid & instr_ready;

    assign ula_ra      = ula_ra_q;
    assign ula_rb      = ula_rb_q;
    assign ula_opcode  = ula_opcode_q;
    assign saida       = saida_q;
    assign saida_valid = saida_valid_q;
    assign zero        = zero_q;

    // Reads always follow the byte on instr; only ESPERA ever consumes them
    banco_regs u_banco_regs (
        .clk       (clk),
        .rst       (rst),
        .ra_addr_i (ins.x),
        .rb_addr_i (ins.y),
        .ra_data_o (rd_a),
        .rb_data_o (rd_b),
        .we_i      (we_d),
        .wa_i      (wa_d),
        .wd_i      (wd_d)
    );

    always_comb begin
        we_d = 1'b0;
        wa_d = ins.x;
        wd_d = rd_b;
        case (state_q)
            ESPERA: begin
                we_d = hs && (ins.funct == F_MOV);
            end
            EXEC: begin
                we_d = 1'b1;
                wa_d = ir_x_q;
                wd_d = ula_result;
            end
            IMED: begin
                we_d = instr_valid;
                wa_d = ir_x_q;
                wd_d = instr;
            end
            default: begin
                we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ESPERA;
            ir_x_q        <= '0;
            ula_ra_q      <= '0;
            ula_rb_q      <= '0;
            ula_opcode_q  <= '0;
            saida_q       <= '0;
            saida_valid_q <= 1'b0;
            zero_q        <= 1'b0;
        end else begin
            saida_valid_q <= 1'b0;
            case (state_q)
                ESPERA: begin
                    if (hs) begin
                        if (is_alu(ins.funct)) begin
                            ula_ra_q     <= rd_a;
                            ula_rb_q     <= rd_b;
                            ula_opcode_q <= ins.funct[OPC_W-1:0];
                            ir_x_q       <= ins.x;
                            state_q      <= EXEC;
                        end else if (ins.funct == F_LI) begin
                            ir_x_q  <= ins.x;
                            state_q <= IMED;
                        end else if (ins.funct == F_OUT) begin
                            saida_q       <= rd_a;
                            saida_valid_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    zero_q  <= (ula_result == '0);
                    state_q <= ESPERA;
                end
                IMED: begin
                    if (instr_valid) begin
                        state_q <= ESPERA;
                    end
                end
                default: begin
                    state_q <= ESPERA;
                end
            endcase
        end
    end

endmodule
